// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment driver.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [3:0]  AN_OFF     = 4'hF;

    typedef logic [1:0] digit_idx_t;

    // Active-low one-cold anode pattern for a digit index.
    function automatic logic [3:0] anode_for(input digit_idx_t d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/scan_timebase.sv
// Scan timebase: digit slot counter, digit index, frame counter and blink phase.
module scan_timebase
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 99999,
    parameter int unsigned BLANK_CYCLES = 100,
    parameter int unsigned BLINK_FRAMES = 62
) (
    input  logic       clk,
    input  logic       rst,
    output digit_idx_t digit,
    output logic       in_blank,
    output logic       frame_start,
    output logic       blink_phase
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic               slot_end;
    logic               frame_end;

    assign slot_end    = (scan_cnt == SCAN_W'(SCAN_DIV));
    assign frame_end   = slot_end && (digit == 2'd3);
    assign in_blank    = (scan_cnt < SCAN_W'(BLANK_CYCLES));
    assign frame_start = (scan_cnt == '0) && (digit == 2'd0);

    // Advance slot/digit every clock; frame and blink phase roll over at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt    <= '0;
            digit       <= 2'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (slot_end) begin
                scan_cnt <= '0;
                digit    <= digit + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            if (frame_end) begin
                if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with blink, decimal
// points, inter-digit blanking and frame-coherent input snapshot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 99999,
    parameter int unsigned BLANK_CYCLES = 100,
    parameter int unsigned BLINK_FRAMES = 62
) (
    input  logic       clk100_i,
    input  logic       rst_i,
    input  logic [6:0] hex3_i,
    input  logic [6:0] hex2_i,
    input  logic [6:0] hex1_i,
    input  logic [6:0] hex0_i,
    input  logic [3:0] blink_mask_i,
    input  logic [3:0] dp_mask_i,
    output logic [3:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    digit_idx_t digit;
    logic       in_blank;
    logic       frame_start;
    logic       blink_phase;

    logic [NUM_DIGITS-1:0][6:0] snap_hex;
    logic [NUM_DIGITS-1:0]      snap_blink;
    logic [NUM_DIGITS-1:0]      snap_dp;

    logic [3:0] an_nxt;
    logic [6:0] seg_nxt;
    logic       dp_nxt;

    scan_timebase #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timebase (
        .clk         (clk100_i),
        .rst         (rst_i),
        .digit       (digit),
        .in_blank    (in_blank),
        .frame_start (frame_start),
        .blink_phase (blink_phase)
    );

    // Capture all display inputs once per frame so a change never tears mid-frame.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            snap_hex   <= {NUM_DIGITS{SEG_OFF}};
            snap_blink <= '0;
            snap_dp    <= '0;
        end else if (frame_start) begin
            snap_hex   <= {hex3_i, hex2_i, hex1_i, hex0_i};
            snap_blink <= blink_mask_i;
            snap_dp    <= dp_mask_i;
        end
    end

    // Select what the bus shows next; blinked-off digits keep their anode asserted.
    always_comb begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (!in_blank) begin
            an_nxt = anode_for(digit);
            if (!(snap_blink[digit] && blink_phase)) begin
                seg_nxt = snap_hex[digit];
                dp_nxt  = ~snap_dp[digit];
            end
        end
    end

    // Register the outputs so the pins are glitch-free.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            an_o  <= AN_OFF;
            seg_o <= SEG_OFF;
            dp_o  <= 1'b1;
        end else begin
            an_o  <= an_nxt;
            seg_o <= seg_nxt;
            dp_o  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=9, BLANK_CYCLES=2, BLINK_FRAMES=2.
module tb_seg7_scan_driver;

    localparam int SD    = 9;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int SLOT  = SD + 1;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] hex3, hex2, hex1, hex0;
    logic [3:0] blink_mask, dp_mask;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk100_i     (clk),
        .rst_i        (rst),
        .hex3_i       (hex3),
        .hex2_i       (hex2),
        .hex1_i       (hex1),
        .hex0_i       (hex0),
        .blink_mask_i (blink_mask),
        .dp_mask_i    (dp_mask),
        .an_o         (an),
        .seg_o        (seg),
        .dp_o         (dp)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int n     = 0;  // clock edges since reset release
    int epoch = 0;  // bumped on each reset release

    // Bench copy of the frame snapshot, taken from its own stimulus.
    logic [6:0] m_hex [4];
    logic [3:0] m_blink;
    logic [3:0] m_dp;

    typedef struct {
        int         ep;
        int         k;
        logic [11:0] v;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (epoch %0d cycle %0d)", tag, got, exp,
                     epoch, n);
        end
    endtask

    function automatic logic [11:0] mk(input logic [3:0] a, input logic [6:0] s, input logic d);
        return {a, s, d};
    endfunction

    // Expected {an,seg,dp} right after edge k, derived from position in the timeline.
    function automatic logic [11:0] expect_out(input int k);
        int         pos;
        int         d;
        logic       ph;
        logic [3:0] a;
        pos = k % SLOT;
        d   = (k / SLOT) % 4;
        ph  = ((k / (FRAME * BF)) % 2) == 1;
        if (pos < BC) return mk(4'hF, 7'h7F, 1'b1);
        a = 4'b0001 << d;
        a = ~a;
        if (m_blink[d] && ph) return mk(a, 7'h7F, 1'b1);
        return mk(a, m_hex[d], ~m_dp[d]);
    endfunction

    task automatic push(input int ep, input int k, input logic [11:0] v);
        vec_t e;
        e.ep = ep;
        e.k  = k;
        e.v  = v;
        vecs.push_back(e);
    endtask

    task automatic tick(input string tag);
        if (n % FRAME == 0) begin
            m_hex[0] = hex0;
            m_hex[1] = hex1;
            m_hex[2] = hex2;
            m_hex[3] = hex3;
            m_blink  = blink_mask;
            m_dp     = dp_mask;
        end
        @(posedge clk);
        #1;
        check(tag, {an, seg, dp}, expect_out(n));
        foreach (vecs[i]) begin
            if (vecs[i].ep == epoch && vecs[i].k == n)
                check($sformatf("vec_e%0d_k%0d", epoch, n), {an, seg, dp}, vecs[i].v);
        end
        n++;
    endtask

    int cnt_d0;

    initial begin
        // Hand-computed points along the timeline.
        push(0, 0,   mk(4'hF, 7'h7F, 1'b1));
        push(0, 1,   mk(4'hF, 7'h7F, 1'b1));
        push(0, 2,   mk(4'hE, 7'h30, 1'b1));
        push(0, 9,   mk(4'hE, 7'h30, 1'b1));
        push(0, 10,  mk(4'hF, 7'h7F, 1'b1));
        push(0, 11,  mk(4'hF, 7'h7F, 1'b1));
        push(0, 12,  mk(4'hD, 7'h24, 1'b1));
        push(0, 22,  mk(4'hB, 7'h79, 1'b1));
        push(0, 37,  mk(4'h7, 7'h40, 1'b1));
        push(0, 40,  mk(4'hF, 7'h7F, 1'b1));
        push(0, 115, mk(4'h7, 7'h40, 1'b1));
        push(0, 135, mk(4'hD, 7'h12, 1'b1));
        push(0, 155, mk(4'h7, 7'h19, 1'b1));
        push(0, 185, mk(4'hB, 7'h79, 1'b1));
        push(0, 265, mk(4'hB, 7'h7F, 1'b1));
        push(0, 275, mk(4'h7, 7'h19, 1'b1));
        push(0, 335, mk(4'hD, 7'h12, 1'b1));
        push(0, 341, mk(4'hF, 7'h7F, 1'b1));
        push(0, 345, mk(4'hB, 7'h79, 1'b0));
        push(0, 425, mk(4'hB, 7'h7F, 1'b1));
        push(0, 465, mk(4'hB, 7'h7F, 1'b1));
        push(1, 1,   mk(4'hF, 7'h7F, 1'b1));
        push(1, 2,   mk(4'hE, 7'h30, 1'b1));
        push(1, 25,  mk(4'hB, 7'h79, 1'b0));
        push(1, 35,  mk(4'h7, 7'h19, 1'b1));

        // Reset state.
        rst        = 1'b1;
        hex3       = 7'h40;
        hex2       = 7'h79;
        hex1       = 7'h24;
        hex0       = 7'h30;
        blink_mask = 4'b0000;
        dp_mask    = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset", {an, seg, dp}, mk(4'hF, 7'h7F, 1'b1));
        rst = 1'b0;

        // Basic scan over two frames.
        cnt_d0 = 0;
        while (n < 2 * FRAME) begin
            tick("scan");
            if (an == 4'hE) cnt_d0++;
        end
        check("d0_active_clocks", 12'(cnt_d0), 12'd16);

        // Frame coherence: change inputs while digit 2 of frame 2 is on.
        while (n < 103) tick("coh");
        hex1 = 7'h12;
        hex3 = 7'h19;
        while (n < 4 * FRAME) tick("coh");

        // Blink on digit 2.
        blink_mask = 4'b0100;
        while (n < 8 * FRAME) tick("blink");

        // Decimal point on digit 2, still blinking.
        dp_mask = 4'b0100;
        while (n < 475) tick("dp");

        // Reset during digit 3 with blink_phase=1.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_1", {an, seg, dp}, mk(4'hF, 7'h7F, 1'b1));
        @(posedge clk);
        #1;
        check("midrst_2", {an, seg, dp}, mk(4'hF, 7'h7F, 1'b1));
        rst   = 1'b0;
        n     = 0;
        epoch = 1;
        while (n < 2 * FRAME) tick("restart");

        // Randomised inputs for 1000 frames.
        for (int f = 0; f < 1000 * FRAME; f++) begin
            hex0       = 7'($urandom);
            hex1       = 7'($urandom);
            hex2       = 7'($urandom);
            hex3       = 7'($urandom);
            blink_mask = 4'($urandom);
            dp_mask    = 4'($urandom);
            tick("rand");
            check("excl", ($countones(~an) <= 1) ? 12'd1 : 12'd0, 12'd1);
            if (an == 4'hF) check("blank_seg", {5'd0, seg}, 12'h07F);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a 4-digit common-anode 7-segment display. Consumes the four per-digit segment patterns produced by the stopwatch (`hex3_o`…`hex0_o`) and drives a shared segment bus plus one anode line per digit. Adds per-digit blinking for the digit-edit modes, per-digit decimal points, inter-digit blanking against ghosting, and frame-coherent input sampling so a value change never tears across a frame.

## Interface
One clock; reset is synchronous and active-high.

Parameters:
- `SCAN_DIV`, 99999: clocks per digit slot minus 1. At 100 MHz: 1 ms slot, 4 ms frame.
- `BLANK_CYCLES`, 100: clocks at the start of each slot with all anodes off. Legal range is 1 ≤ `BLANK_CYCLES` ≤ `SCAN_DIV`.
- `BLINK_FRAMES`, 62: frames per blink half-period (about 2 Hz at the defaults). Must be ≥ 1.

Ports:
- `clk100_i` in 1: system clock, 100 MHz.
- `rst_i` in 1: synchronous, active-high reset.
- `hex3_i`, `hex2_i`, `hex1_i`, `hex0_i` in 7 each: segment patterns, active-low. `hex3_i` is the leftmost digit.
- `blink_mask_i` in 4: bit k=1 makes digit k blink.
- `dp_mask_i` in 4: bit k=1 lights the decimal point of digit k.
- `an_o` out 4: anode enables, active-low. Bit k selects digit k.
- `seg_o` out 7: shared segment bus, active-low.
- `dp_o` out 1: shared decimal point, active-low.

## Operation
- **Counters:**
  - `scan_cnt` counts 0..`SCAN_DIV`.
  - `digit` is 2 bits, counting 0→1→2→3→0.
  - `frame_cnt` counts 0..`BLINK_FRAMES`-1.
  - `blink_phase` is 1 bit; 0 means visible.
- **Slot end** (`scan_cnt`==`SCAN_DIV`): `scan_cnt`←0 and `digit`←`digit`+1, wrapping 3→0.
- **Frame end** (slot end with `digit`==3): `frame_cnt` advances. When `frame_cnt` is at `BLINK_FRAMES`-1 it returns to 0 and `blink_phase` toggles.
- **Snapshot:**
  - Condition: `scan_cnt`==0 and `digit`==0 (frame start).
  - Registered on that cycle: the four `hex*_i`, `blink_mask_i` and `dp_mask_i`.
  - Inputs are ignored at all other times.
- **Output decision** (from the current counters and the snapshot):
  - **Blank window** (`scan_cnt` < `BLANK_CYCLES`): `an_o`=4'hF, `seg_o`=7'h7F, `dp_o`=1.
  - **Active window:** `an_o`=~(1<<`digit`).
    - If `snap_blink[digit]` & `blink_phase`: `seg_o`=7'h7F and `dp_o`=1. The anode stays asserted.
    - Otherwise: `seg_o`=`snap_hex[digit]` and `dp_o`=~`snap_dp[digit]`.
- **Exclusivity:** at most one `an_o` bit is low in any cycle, and never in the blank window.

## Timing
- **Outputs are registered:** the output in cycle t+1 reflects the counters and snapshot in cycle t.
- **Reset values:**
  - `an_o`=4'hF, `seg_o`=7'h7F, `dp_o`=1.
  - All counters 0, `blink_phase`=0.
  - Snapshot: all patterns 7'h7F, masks 0.
- **After reset release:**
  - The first clock with `rst_i`=0 is a frame start, so the snapshot loads on that cycle.
  - Digit 0 is first driven on output cycle `BLANK_CYCLES`+1 after reset release.
- **No snapshot/output hazard:** a snapshot load always falls inside a blank window, because `BLANK_CYCLES` ≥ 1.
- **Input-to-display latency:** worst case one frame plus `BLANK_CYCLES`+1 clocks.
- **Slot length:** each digit slot lasts `SCAN_DIV`+1 clocks, of which `SCAN_DIV`+1-`BLANK_CYCLES` have the anode active.
- **Blink:** half-period = `BLINK_FRAMES`·4·(`SCAN_DIV`+1) clocks. `blink_phase` changes only at frame boundaries.
- **Reset asserted mid-frame:** all state returns to the reset values on the next edge. No partial slot completes.
- **`BLANK_CYCLES`==`SCAN_DIV`:** the slot has exactly one active clock.

## Structure
- **Shared package `seg7_pkg`:** `NUM_DIGITS`=4, `SEG_OFF`=7'h7F, `AN_OFF`=4'hF, and the 2-bit `digit_idx_t` typedef.
- **Sub-module `scan_timebase`:**
  - Owns `scan_cnt`, `digit`, `frame_cnt` and `blink_phase`.
  - Outputs `digit`, `in_blank`, `frame_start` and `blink_phase`.
- **Top level:** snapshot registers, output mux and output registers.

## Test plan
All scenarios use `SCAN_DIV`=9, `BLANK_CYCLES`=2 and `BLINK_FRAMES`=2.

1. **Basic scan:** hold `hex3..0`=7'h40,7'h79,7'h24,7'h30, masks 0, then release reset.
   - `an_o` walks 4'hE,D,B,7, each for 8 clocks, separated by 2 clocks of 4'hF.
   - `seg_o` matches the digit and the cycle count is exact.
2. **Frame coherence:** change `hex1_i` mid-frame while digit 2 is being driven.
   - Digit 1 keeps the old pattern in the current frame.
   - The new pattern appears in the next frame.
3. **Blink:** `blink_mask_i`=4'b0100.
   - Digit 2 shows its pattern for 2 frames (80 clocks), then 7'h7F with `an_o`=4'hB for 2 frames, repeating.
   - Other digits are unaffected.
4. **Decimal point:** `dp_mask_i`=4'b0100.
   - `dp_o`=0 only during digit 2 active clocks.
   - `dp_o`=1 in blank windows and during the blinked-off phase when combined with scenario 3.
5. **Mid-frame reset:** assert `rst_i` during digit 3 with `blink_phase`=1.
   - Next cycle: `an_o`=4'hF, `seg_o`=7'h7F, `dp_o`=1.
   - Restart follows scenario 1's timing with `blink_phase`=0.
6. **Anode exclusivity:** run randomised inputs for 1000 frames.
   - Assert `an_o` never has more than one zero bit.
   - Assert `seg_o`=7'h7F whenever `an_o`=4'hF.
